// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment check.
// Purely declarative; no latency or backpressure of its own.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_MERGE  = 2'b10,
        ST_RESP   = 2'b11
    } lsu_state_e;

    // True for size 2'b11 and for any access not aligned to its own size.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_illegal = 1'b0;
            SZ_HALF: is_illegal = lo[0];
            SZ_WORD: is_illegal = (lo != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Request/response and memDATA bus bundle for the load/store unit.
// slave = the LSU itself; master = pipeline plus memory model that surround it.
interface lsu_mem_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_if_lane_align.sv
// Byte-lane steering: extracts/extends a sub-word load and merges store data into a word.
// Combinational, zero latency; no handshake.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SZ_BYTE: load_o = uns_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_o = uns_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: load_o = word_i;
            default: load_o = 32'd0;
        endcase

        merge_o = word_i;
        case (size_i)
            SZ_BYTE: merge_o[{addr_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_HALF: merge_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit to memDATA: word addressing, sub-word RMW stores, extended loads. Optional LSU_PERF_CNT_EN counters.
// Accept-to-resp: error 1, load/word store 2, sub-word store 3 cycles; req_ready low while busy.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_mem_if_if.slave bus,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] err_cnt
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merge;
    logic              word_store;

    // During MERGE the aligner works on the captured old word, otherwise on live memory data.
    assign lane_word  = (state_q == ST_MERGE) ? buf_q : bus.mem_rdata;
    assign word_store = we_q && (size_q == SZ_WORD);

    lsu_lane_align u_align (
        .word_i  (lane_word),
        .addr_i  (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = is_illegal(bus.req_size, bus.req_addr[1:0]);
                    rdata_d = '0;
                    state_d = err_d ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q && !word_store) begin
                    buf_d   = bus.mem_rdata;
                    state_d = ST_MERGE;
                end else begin
                    if (!we_q) rdata_d = lane_load;
                    state_d = ST_RESP;
                end
            end
            ST_MERGE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_err   = (state_q == ST_RESP) && err_q;
        bus.resp_rdata = rdata_q;
        bus.mem_addr   = {2'b00, addr_q[ADDR_W-1:2]};
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        if (state_q == ST_ACCESS && word_store) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = wdata_q;
        end else if (state_q == ST_MERGE) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = lane_merge;
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, store_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (state_q == ST_RESP) begin
            if (err_q)     err_cnt_q   <= err_cnt_q + 32'd1;
            else if (we_q) store_cnt_q <= store_cnt_q + 32'd1;
            else           load_cnt_q  <= load_cnt_q + 32'd1;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign load_cnt  = 32'd0;
    assign store_cnt = 32'd0;
    assign err_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a behavioural memDATA and a response scoreboard.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] load_cnt, store_cnt, err_cnt;
    logic [31:0] mem [0:255];

    int   tests;
    int   fails;
    exp_t sb[$];

    int          we_cycles;
    logic [31:0] we_addr;
    logic [31:0] we_data;

    lsu_mem_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every resp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            chk("resp_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                chk("resp_rdata", bus.resp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_lat, input string tag);
        int  n;
        int  lat;
        bit  done;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb.push_back(e);
        we_cycles = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat  = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) begin
                we_cycles++;
                we_addr = bus.mem_addr;
                we_data = bus.mem_wdata;
            end
            if (bus.resp_valid) done = 1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int accepts;
        int resps;
        exp_t e;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset state, with a request presented that must be ignored.
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_load_cnt", load_cnt, 32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Word store then load back.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, "st_w10");
        chk("st_w10_we_cycles", we_cycles, 1);
        chk("st_w10_mem_addr", we_addr, 32'h4);
        chk("st_w10_mem_wdata", we_data, 32'hDEAD_BEEF);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, "ld_w10");
        chk("ld_w10_we_cycles", we_cycles, 0);

        // Byte store read-modify-write.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'h0, 2, "st_w20");
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h0000_00AA, 1'b0, 32'h0, 3, "st_b22");
        chk("st_b22_we_cycles", we_cycles, 1);
        chk("st_b22_mem_addr", we_addr, 32'h8);
        chk("st_b22_merge", we_data, 32'h11AA_3344);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11AA_3344, 2, "ld_w20");

        // Sub-word loads with sign/zero extension, and a halfword store.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h8000_FF80, 1'b0, 32'h0, 2, "st_w30");
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h30, 32'h0, 1'b0, 32'hFFFF_FF80, 2, "ld_bs30");
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h30, 32'h0, 1'b0, 32'h0000_0080, 2, "ld_bu30");
        do_req(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, 1'b0, 32'hFFFF_8000, 2, "ld_hs32");
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h31, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, "ld_bs31");
        do_req(1'b1, SZ_HALF, 1'b0, 32'h32, 32'hFFFF_BEEF, 1'b0, 32'h0, 3, "st_h32");
        chk("st_h32_merge", we_data, 32'hBEEF_FF80);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, 1'b0, 32'h0000_BEEF, 2, "ld_hu32");

        // Illegal requests: no memory write, 1-cycle error response.
        do_req(1'b0, SZ_WORD, 1'b0, 32'h31, 32'h0, 1'b1, 32'h0, 1, "err_w31");
        chk("err_w31_we_cycles", we_cycles, 0);
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, "err_sz3");
        chk("err_sz3_we_cycles", we_cycles, 0);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h33, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, "err_h33");
        chk("err_h33_we_cycles", we_cycles, 0);

        // Top-of-range address maps to the highest word.
        do_req(1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, mem[8'hFF], 2, "ld_top");

        // req_valid held high: one accept per transaction.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e.err   = 1'b0;
            e.rdata = 32'hDEAD_BEEF;
            sb.push_back(e);
        end
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_valid    = 1'b1;
        accepts = 0;
        resps   = 0;
        for (int i = 0; i < 30 && resps < 3; i++) begin
            if (bus.req_valid && bus.req_ready) accepts++;
            @(negedge clk);
            if (bus.resp_valid) resps++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", accepts, 3);
        chk("b2b_resps", resps, 3);
        @(negedge clk);

        // Reset during MERGE of a byte store aborts it.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h5566_7788, 1'b0, 32'h0, 2, "st_w40");
        while (!bus.req_ready) @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 32'h41;
        bus.req_wdata = 32'h0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_merge_we", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'd0, bus.mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resps = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) resps++;
        end
        chk("abort_no_resp", resps, 0);
        chk("abort_mem_kept", mem[8'h10], 32'h5566_7788);

        // Counter workload after reset: 3 loads, 2 stores, 1 error.
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h5566_7788, 2, "cnt_ld1");
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_00EF, 2, "cnt_ld2");
        do_req(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_3344, 2, "cnt_ld3");
        do_req(1'b1, SZ_WORD, 1'b0, 32'h50, 32'hA5A5_5A5A, 1'b0, 32'h0, 2, "cnt_st1");
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h51, 32'h0000_0011, 1'b0, 32'h0, 3, "cnt_st2");
        chk("cnt_st2_merge", we_data, 32'hA5A5_115A);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h52, 32'h0, 1'b1, 32'h0, 1, "cnt_err");
        repeat (2) @(negedge clk);
`ifdef LSU_PERF_CNT_EN
        chk("load_cnt", load_cnt, 32'd3);
        chk("store_cnt", store_cnt, 32'd2);
        chk("err_cnt", err_cnt, 32'd1);
`else
        chk("load_cnt", load_cnt, 32'd0);
        chk("store_cnt", store_cnt, 32'd0);
        chk("err_cnt", err_cnt, 32'd0);
`endif
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the execute stage and the data memory `memDATA`.
- Accepts one byte/halfword/word load or store request at a time.
- Converts byte addresses to word addresses for `memDATA`.
- Does read-modify-write for sub-word stores, and extracts plus sign/zero-extends sub-word loads.
- Returns a one-cycle response pulse to the pipeline.

Parameters:
- `ADDR_W`, 32, byte-address width of pipeline requests and of `mem_addr`.
- `DATA_W`, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit can accept a request (high only in IDLE).
- `req_we`  input  1  1 = store, 0 = load.
- `req_size`  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  input  ADDR_W  byte address.
- `req_wdata`  input  DATA_W  store data, right-aligned.
- `resp_valid`  output  1  one-cycle completion pulse.
- `resp_rdata`  output  DATA_W  load result (0 for stores and errors).
- `resp_err`  output  1  misaligned or illegal-size request; qualified by `resp_valid`.
- `mem_addr`  output  ADDR_W  word address to `memDATA` (`req_addr>>2`, zero-filled).
- `mem_we`  output  1  `memDATA` write enable (`MW`).
- `mem_wdata`  output  DATA_W  `memDATA` write data.
- `mem_rdata`  input  DATA_W  `memDATA` read data.
- `load_cnt`, `store_cnt`, `err_cnt`  output  32 each  performance counters (see Optional Feature).

Behaviour:
- `memDATA` contract: combinational read of `mem_addr`; write on rising `clk` when `mem_we`=1.
- Reset values (asynchronous, `rst_n`=0):
  - state = IDLE; `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Latched request registers cleared; counters = 0.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - On `req_valid`&&`req_ready`, latch we/size/unsigned/addr/wdata.
  - If illegal (size=11, halfword with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err flag set; no memory access ever issued.
  - Otherwise go to ACCESS.
  - `mem_addr` tracks the latched address in every non-IDLE state; `mem_we`=0 in IDLE.
- ACCESS:
  - Word store: `mem_we`=1, `mem_wdata`=latched wdata; next RESP.
  - Sub-word store: `mem_we`=0; register `mem_rdata` into the merge buffer; next MERGE.
  - Load: register the extracted lane of `mem_rdata` into `resp_rdata`; next RESP.
- MERGE:
  - `mem_we`=1.
  - `mem_wdata` = merge buffer with the addressed lane(s) replaced: byte lane addr[1:0]; halfword lane addr[1].
  - Next RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle; `resp_err` = err flag.
  - `resp_rdata` = 0 if store or err.
  - Next IDLE.
- Lane and extension rules:
  - Byte lane n = bits [8n+7:8n].
  - Sign-extend from bit 7 (byte) or bit 15 (halfword) when `req_unsigned`=0.
  - Little-endian.
- Latency, accept edge to `resp_valid` high:
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: `req_ready` is low from ACCESS through RESP. Requests presented then are ignored; the requester must hold them.
- `req_addr` upper bits ADDR_W-1:2 pass through unchanged. Address 0xFFFFFFFC maps to word 0x3FFFFFFF; no wrap handling required.
- Reset asserted mid-operation:
  - `mem_we` drops immediately (asynchronous).
  - A store not yet committed by a rising edge is lost.
  - No `resp_valid` is issued for the aborted request.
- `req_valid` during reset is ignored.

Optional Feature:
- Macro `LSU_PERF_CNT_EN`.
- Defined:
  - `load_cnt` increments by 1 in RESP for a successful load.
  - `store_cnt` increments by 1 in RESP for a successful store.
  - `err_cnt` increments by 1 in RESP for an errored request.
  - 32-bit, wrap 0xFFFFFFFF→0, cleared by reset.
- Undefined: the three ports are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package `lsu_pkg`:
  - Size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
  - State encoding `ST_IDLE`/`ST_ACCESS`/`ST_MERGE`/`ST_RESP`.
- One natural combinational sub-module, `lsu_lane_align`:
  - Inputs: word, addr[1:0], size, unsigned, store data.
  - Outputs: extended load data and merged store word.
- FSM and registers stay in `lsu_mem_if`.

Test Plan:
- Word store 0xDEADBEEF @ byte 0x10, then word load @ 0x10:
  - `mem_addr`=0x4 with `mem_we` high one cycle.
  - Load `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 2 cycles after accept.
- Preload word 0x11223344 @ 0x20; byte store 0xAA @ 0x22:
  - `mem_wdata`=0x11AA3344 in MERGE.
  - `resp_valid` 3 cycles after accept.
- Word 0x8000FF80 @ 0x30:
  - Signed byte load @ 0x30 → 0xFFFFFF80.
  - Unsigned byte load @ 0x30 → 0x00000080.
  - Signed half load @ 0x32 → 0xFFFF8000.
- Misaligned requests:
  - Word load @ 0x31 → `resp_err`=1, `resp_rdata`=0, 1-cycle latency, `mem_we` never asserted.
  - size=11 store → same result.
- Back-to-back `req_valid` held high: only one accept per transaction (`req_ready` low ACCESS..RESP); every request gets exactly one `resp_valid`.
- Reset mid-operation:
  - Assert `rst_n`=0 in MERGE of a byte store → `mem_we` falls immediately, memory word unchanged, no `resp_valid`.
  - With `LSU_PERF_CNT_EN`: after 3 loads, 2 stores, 1 error, counters read 3/2/1.
